// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types and register-window constants for the data-memory subsystem
package dmem_pkg;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_CPU,
        OWN_DMA
    } owner_t;

    typedef enum logic [1:0] {
        REG_RAM,
        REG_IO,
        REG_OOR
    } region_t;

    localparam logic [1:0] IO_CYCLES = 2'd0;
    localparam logic [1:0] IO_DMACNT = 2'd1;
    localparam logic [1:0] IO_CTRL   = 2'd2;
    localparam logic [1:0] IO_STATUS = 2'd3;

    localparam int CTRL_DMA_EN_BIT = 0;

endpackage

// File: rtl/dmem_ram.sv
// rtl/dmem_ram.sv - single-port synchronous RAM with per-byte write lanes
module dmem_ram #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 1024
) (
    input  logic                       clk,
    input  logic                       en,
    input  logic                       we,
    input  logic [DATA_W/8-1:0]        be,
    input  logic [$clog2(DEPTH)-1:0]   addr,
    input  logic [DATA_W-1:0]          wdata,
    output logic [DATA_W-1:0]          q
);

    logic [DATA_W-1:0] mem [DEPTH];

    // q only moves on a read, so it stays valid until the next read access
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                for (int i = 0; i < DATA_W/8; i++) begin
                    if (be[i]) begin
                        mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
                    end
                end
            end else begin
                q <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/dmem_subsystem.sv
// rtl/dmem_subsystem.sv - CPU/DMA arbitrated data memory with a 4-register IO window
// Optional BYTE_WE_EN adds cpu_be/dma_be byte-lane write enables.
module dmem_subsystem
    import dmem_pkg::*;
#(
    parameter int                DATA_W      = 32,
    parameter int                ADDR_W      = 32,
    parameter int                DEPTH_WORDS = 1024,
    parameter logic [ADDR_W-1:0] IO_BASE     = 'h0000_F000,
    parameter int                STARVE_LIM  = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cpu_req,
    input  logic                 cpu_we,
    input  logic [ADDR_W-1:0]    cpu_addr,
    input  logic [DATA_W-1:0]    cpu_wdata,
`ifdef BYTE_WE_EN
    input  logic [DATA_W/8-1:0]  cpu_be,
    input  logic [DATA_W/8-1:0]  dma_be,
`endif
    output logic                 cpu_stall,
    output logic                 cpu_rvalid,
    output logic [DATA_W-1:0]    cpu_rdata,
    input  logic                 dma_req,
    input  logic                 dma_we,
    input  logic [ADDR_W-1:0]    dma_addr,
    input  logic [DATA_W-1:0]    dma_wdata,
    output logic                 dma_gnt,
    output logic                 dma_rvalid,
    output logic [DATA_W-1:0]    dma_rdata,
    output logic                 err_addr
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam int BE_W  = DATA_W / 8;
    localparam int STV_W = $clog2(STARVE_LIM + 1);
    localparam logic [ADDR_W:0] RAM_END = (ADDR_W+1)'(DEPTH_WORDS * 4);
    localparam logic [ADDR_W:0] IO_LO   = {1'b0, IO_BASE};
    localparam logic [ADDR_W:0] IO_END  = IO_LO + (ADDR_W+1)'(16);

    logic [31:0]       cycles;
    logic [31:0]       dma_cnt;
    logic              dma_en;
    logic [STV_W-1:0]  starve;
    owner_t            rd_owner;
    logic              rd_ram;
    logic [DATA_W-1:0] rd_io;
    logic [DATA_W-1:0] cpu_hold;
    logic [DATA_W-1:0] dma_hold;

    logic              forced;
    logic              cpu_win;
    logic              dma_win;
    logic              acc;
    logic              acc_we;
    logic [ADDR_W-1:0] acc_addr;
    logic [DATA_W-1:0] acc_wdata;
    logic [BE_W-1:0]   acc_be;
    region_t           acc_region;
    logic [1:0]        io_off;
    logic [DATA_W-1:0] io_rdata;
    logic [DATA_W-1:0] ram_q;
    logic [DATA_W-1:0] rd_value;
    logic              status_clr;

    // Grants are suppressed while reset is held so the un-reset RAM cannot be written then
    assign forced  = dma_en & dma_req & (starve == STV_W'(STARVE_LIM));
    assign cpu_win = reset & cpu_req & ~forced;
    assign dma_win = reset & dma_en & dma_req & (~cpu_req | forced);

    assign cpu_stall = reset & cpu_req & ~cpu_win;
    assign dma_gnt   = dma_win;

    assign acc       = cpu_win | dma_win;
    assign acc_we    = dma_win ? dma_we    : cpu_we;
    assign acc_addr  = dma_win ? dma_addr  : cpu_addr;
    assign acc_wdata = dma_win ? dma_wdata : cpu_wdata;
`ifdef BYTE_WE_EN
    assign acc_be    = dma_win ? dma_be    : cpu_be;
`else
    assign acc_be    = '1;
`endif

    // IO_BASE is assumed 16-byte aligned, so addr[3:2] is the register offset
    assign io_off = acc_addr[3:2];

    always_comb begin
        acc_region = REG_OOR;
        if ({1'b0, acc_addr} < RAM_END) begin
            acc_region = REG_RAM;
        end else if ({1'b0, acc_addr} >= IO_LO && {1'b0, acc_addr} < IO_END) begin
            acc_region = REG_IO;
        end
    end

    always_comb begin
        io_rdata = '0;
        case (io_off)
            IO_CYCLES: io_rdata = DATA_W'(cycles);
            IO_DMACNT: io_rdata = DATA_W'(dma_cnt);
            IO_CTRL:   io_rdata[CTRL_DMA_EN_BIT] = dma_en;
            IO_STATUS: io_rdata[0] = err_addr;
            default:   io_rdata = '0;
        endcase
    end

    assign status_clr = acc && acc_we && acc_region == REG_IO && io_off == IO_STATUS
                        && (|acc_be) && acc_wdata[0];

    dmem_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH_WORDS)
    ) u_ram (
        .clk   (clk),
        .en    (acc && acc_region == REG_RAM),
        .we    (acc_we),
        .be    (acc_be),
        .addr  (acc_addr[IDX_W+1:2]),
        .wdata (acc_wdata),
        .q     (ram_q)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cycles   <= '0;
            dma_cnt  <= '0;
            dma_en   <= 1'b0;
            starve   <= '0;
            err_addr <= 1'b0;
            rd_owner <= OWN_NONE;
            rd_ram   <= 1'b0;
            rd_io    <= '0;
            cpu_hold <= '0;
            dma_hold <= '0;
        end else begin
            cycles <= cycles + 32'd1;
            if (dma_win) begin
                dma_cnt <= dma_cnt + 32'd1;
            end

            if (!dma_req || dma_win) begin
                starve <= '0;
            end else if (cpu_req && starve != STV_W'(STARVE_LIM)) begin
                starve <= starve + STV_W'(1);
            end

            rd_owner <= OWN_NONE;
            if (acc && !acc_we) begin
                rd_owner <= dma_win ? OWN_DMA : OWN_CPU;
                rd_ram   <= acc_region == REG_RAM;
                rd_io    <= (acc_region == REG_IO) ? io_rdata : '0;
            end

            if (acc && acc_we && acc_region == REG_IO && (|acc_be) && io_off == IO_CTRL) begin
                dma_en <= acc_wdata[CTRL_DMA_EN_BIT];
            end

            if (acc && acc_region == REG_OOR) begin
                err_addr <= 1'b1;
            end else if (status_clr) begin
                err_addr <= 1'b0;
            end

            if (cpu_rvalid) begin
                cpu_hold <= rd_value;
            end
            if (dma_rvalid) begin
                dma_hold <= rd_value;
            end
        end
    end

    assign rd_value   = rd_ram ? ram_q : rd_io;
    assign cpu_rvalid = rd_owner == OWN_CPU;
    assign dma_rvalid = rd_owner == OWN_DMA;
    assign cpu_rdata  = cpu_rvalid ? rd_value : cpu_hold;
    assign dma_rdata  = dma_rvalid ? rd_value : dma_hold;

endmodule

// File: tb/tb_dmem_subsystem.sv
// tb/tb_dmem_subsystem.sv - randomized model-checked bench for dmem_subsystem
module tb_dmem_subsystem;

    localparam logic [31:0] IO_B = 32'h0000_F000;
    localparam int          LIM  = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        cpu_req = 1'b0, cpu_we = 1'b0;
    logic [31:0] cpu_addr = '0, cpu_wdata = '0;
    logic        dma_req = 1'b0, dma_we = 1'b0;
    logic [31:0] dma_addr = '0, dma_wdata = '0;
    logic        cpu_stall, cpu_rvalid, dma_gnt, dma_rvalid, err_addr;
    logic [31:0] cpu_rdata, dma_rdata;
`ifdef BYTE_WE_EN
    logic [3:0]  cpu_be = 4'hF, dma_be = 4'hF;
`endif

    always #5 clk = ~clk;

    dmem_subsystem #(
        .DATA_W(32), .ADDR_W(32), .DEPTH_WORDS(1024), .IO_BASE(IO_B), .STARVE_LIM(LIM)
    ) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
`ifdef BYTE_WE_EN
        .cpu_be(cpu_be), .dma_be(dma_be),
`endif
        .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
        .err_addr(err_addr)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state: memory image, register window, pending read, last delivered data
    logic [31:0] m_mem [1024];
    logic [31:0] m_cyc, m_dmacnt;
    logic        m_ctrl, m_err;
    int          m_starve;
    int          m_pend;
    logic [31:0] m_pdata, m_last_cpu, m_last_dma;

    logic        obs_stall, obs_gnt, obs_crv, obs_drv, obs_err;
    logic [31:0] obs_crd, obs_drd;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic m_reset();
        m_cyc = '0; m_dmacnt = '0; m_ctrl = 1'b0; m_err = 1'b0; m_starve = 0;
        m_pend = 0; m_pdata = '0; m_last_cpu = '0; m_last_dma = '0;
    endtask

    function automatic logic is_oor(input logic [31:0] a);
        return !(a < 32'd4096 || (a >= IO_B && a < IO_B + 32'd16));
    endfunction

    function automatic logic [31:0] m_read(input logic [31:0] a);
        if (a < 32'd4096) return m_mem[a[11:2]];
        if (a >= IO_B && a < IO_B + 32'd16) begin
            case (a[3:2])
                2'd0:    return m_cyc;
                2'd1:    return m_dmacnt;
                2'd2:    return {31'b0, m_ctrl};
                default: return {31'b0, m_err};
            endcase
        end
        return 32'd0;
    endfunction

    task automatic m_write(input logic [31:0] a, input logic [31:0] d);
        if (a < 32'd4096) m_mem[a[11:2]] = d;
        else if (a == IO_B + 32'd8) m_ctrl = d[0];
        else if (a[31:2] == IO_B[31:2] + 30'd3 && d[0]) m_err = 1'b0;
    endtask

    // One clock cycle: drive, compare against the model at negedge, advance the model
    task automatic step(input logic cr, input logic cw, input logic [31:0] ca, input logic [31:0] cd,
                        input logic dr, input logic dw, input logic [31:0] da, input logic [31:0] dd);
        logic forced, cg, dg, w;
        logic [31:0] a, d;
        cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
        dma_req = dr; dma_we = dw; dma_addr = da; dma_wdata = dd;
        forced = m_ctrl && dr && m_starve == LIM;
        cg = cr && !forced;
        dg = dr && m_ctrl && (!cr || forced);
        @(negedge clk);
        obs_stall = cpu_stall; obs_gnt = dma_gnt; obs_crv = cpu_rvalid; obs_drv = dma_rvalid;
        obs_crd = cpu_rdata; obs_drd = dma_rdata; obs_err = err_addr;
        chk("cpu_stall", 32'(cpu_stall), 32'(cr && !cg));
        chk("dma_gnt", 32'(dma_gnt), 32'(dg));
        chk("cpu_rvalid", 32'(cpu_rvalid), 32'(m_pend == 1));
        chk("dma_rvalid", 32'(dma_rvalid), 32'(m_pend == 2));
        chk("cpu_rdata", cpu_rdata, (m_pend == 1) ? m_pdata : m_last_cpu);
        chk("dma_rdata", dma_rdata, (m_pend == 2) ? m_pdata : m_last_dma);
        chk("err_addr", 32'(err_addr), 32'(m_err));
        if (m_pend == 1) m_last_cpu = m_pdata;
        if (m_pend == 2) m_last_dma = m_pdata;
        m_pend = 0;
        if (cg || dg) begin
            a = cg ? ca : da; d = cg ? cd : dd; w = cg ? cw : dw;
            if (!w) begin
                m_pdata = m_read(a);
                m_pend = cg ? 1 : 2;
            end else begin
                m_write(a, d);
            end
            if (is_oor(a)) m_err = 1'b1;
        end
        if (dg) m_dmacnt++;
        if (!dr || dg) m_starve = 0;
        else if (cr && m_starve < LIM) m_starve++;
        m_cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_wr(input logic [31:0] a, input logic [31:0] d);
        step(1'b1, 1'b1, a, d, 1'b0, 1'b0, '0, '0);
    endtask
    task automatic cpu_rd(input logic [31:0] a);
        step(1'b1, 1'b0, a, '0, 1'b0, 1'b0, '0, '0);
    endtask
    task automatic idle();
        step(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
    endtask

    function automatic logic [31:0] rand_addr();
        int k;
        logic [31:0] oor [5];
        oor[0] = 32'h1000; oor[1] = 32'h2000; oor[2] = 32'hF010;
        oor[3] = 32'hFFFF_FFFC; oor[4] = 32'hEFFC;
        k = $urandom_range(0, 9);
        if (k < 6) return (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
        if (k < 8) return IO_B + (32'($urandom_range(0, 3)) << 2);
        return oor[$urandom_range(0, 4)];
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [14:0] gnt_seq;
        logic [31:0] v1, v2;
        m_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs", {25'b0, cpu_stall, dma_gnt, cpu_rvalid, dma_rvalid, err_addr,
                              |cpu_rdata, |dma_rdata}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;

        for (int w = 0; w < 16; w++) cpu_wr(32'(w) << 2, $urandom);

        cpu_wr(32'h10, 32'hDEAD_BEEF);
        chk("t1_wr_stall", 32'(obs_stall), 32'd0);
        cpu_rd(32'h10);
        chk("t1_rd_stall", 32'(obs_stall), 32'd0);
        idle();
        chk("t1_rvalid", 32'(obs_crv), 32'd1);
        chk("t1_rdata", obs_crd, 32'hDEAD_BEEF);
        chk("t1_dma_rvalid", 32'(obs_drv), 32'd0);

        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 32'h20, '0);
            chk("dis_gnt", 32'(obs_gnt), 32'd0);
        end
        cpu_rd(IO_B + 32'd4);
        idle();
        chk("dis_dmacnt", obs_crd, 32'd0);

        cpu_wr(IO_B + 32'd8, 32'd1);
        for (int i = 0; i < 15; i++) begin
            step(1'b1, 1'b0, 32'h8, '0, 1'b1, 1'b0, 32'h24, '0);
            gnt_seq[i] = obs_gnt;
        end
        chk("starve_pattern", {17'b0, gnt_seq}, 32'h0000_4210);
        cpu_rd(IO_B + 32'd4);
        idle();
        chk("starve_dmacnt", obs_crd, 32'd3);

        cpu_wr(32'h0, 32'h1234_5678);
        cpu_wr(32'h2000, 32'hFFFF_FFFF);
        idle();
        chk("oor_err_set", 32'(obs_err), 32'd1);
        cpu_rd(IO_B + 32'd12);
        idle();
        chk("oor_status_rd", obs_crd, 32'd1);
        cpu_wr(IO_B + 32'd12, 32'd1);
        idle();
        chk("oor_err_clr", 32'(obs_err), 32'd0);
        cpu_rd(32'h0);
        idle();
        chk("oor_ram_kept", obs_crd, 32'h1234_5678);

        cpu_rd(IO_B);
        idle();
        v1 = obs_crd;
        idle();
        cpu_rd(IO_B);
        idle();
        v2 = obs_crd;
        chk("cycles_delta", v2 - v1, 32'd3);
        cpu_wr(IO_B, 32'h55);
        cpu_rd(IO_B);
        idle();
        chk("cycles_ro", 32'(obs_crd == 32'h55), 32'd0);

        for (int i = 0; i < 500; i++) begin
            logic cr, dr, cw, dw;
            logic [31:0] ca, da;
            cr = ($urandom_range(0, 3) != 0);
            dr = ($urandom_range(0, 3) != 0);
            cw = ($urandom_range(0, 2) == 0);
            dw = ($urandom_range(0, 2) == 0);
            ca = rand_addr();
            da = rand_addr();
            step(cr, cw, ca, $urandom, dr, dw, da, $urandom);
        end

        cpu_wr(IO_B + 32'd8, 32'd1);
        cpu_rd(32'h10);
        reset = 1'b0;
        cpu_req = 1'b0; dma_req = 1'b0; cpu_we = 1'b0; dma_we = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_rvalid", 32'({cpu_rvalid, dma_rvalid}), 32'd0);
            chk("rst_outputs", {25'b0, cpu_stall, dma_gnt, cpu_rvalid, dma_rvalid, err_addr,
                                |cpu_rdata, |dma_rdata}, 32'd0);
        end
        @(posedge clk); #1;
        reset = 1'b1;
        m_reset();
        cpu_rd(IO_B + 32'd8);
        idle();
        chk("rst_ctrl_rvalid", 32'(obs_crv), 32'd1);
        chk("rst_ctrl", obs_crd, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_subsystem.md
Name: dmem_subsystem

Overview:
- Parametrised data-memory subsystem between the pipelined ARM core and data RAM for the image equalizer.
- Adds a second requester port (DMA/image loader), fair arbitration and registered 1-cycle reads with ready/valid handshakes.
- Adds a small memory-mapped register window (cycle counter, DMA access counter, control, error status).

Parameters:
- DATA_W, 32, data word width (multiple of 8)
- ADDR_W, 32, byte-address width
- DEPTH_WORDS, 1024, RAM depth in words (power of 2)
- IO_BASE, 32'h0000_F000, byte base of register window (4 word regs)
- STARVE_LIM, 4, max consecutive contested cycles DMA may lose before forced grant

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- cpu_req  in  1  CPU access request
- cpu_we  in  1  CPU write (1) / read (0)
- cpu_addr  in  ADDR_W  CPU byte address
- cpu_wdata  in  DATA_W  CPU write data
- cpu_stall  out  1  CPU request not accepted this cycle
- cpu_rvalid  out  1  CPU read data valid
- cpu_rdata  out  DATA_W  CPU read data
- dma_req  in  1  DMA access request
- dma_we  in  1  DMA write / read
- dma_addr  in  ADDR_W  DMA byte address
- dma_wdata  in  DATA_W  DMA write data
- dma_gnt  out  1  DMA request accepted this cycle
- dma_rvalid  out  1  DMA read data valid
- dma_rdata  out  DATA_W  DMA read data
- err_addr  out  1  sticky out-of-range access flag

Behaviour:
- Reset (reset=0, async): all outputs 0; counters, CTRL, starvation counter, err flag cleared. RAM contents not cleared.
- Word index = addr[log2(DEPTH_WORDS)+1:2]; addr[1:0] ignored.
- Decode: addr < DEPTH_WORDS*4 → RAM; IO_BASE ≤ addr < IO_BASE+16 → register; anything else → out-of-range.
- Arbitration, combinational per cycle:
  - Only one requester → that requester is granted.
  - Both requesting → CPU wins, unless CTRL.dma_en=1 and the starve counter = STARVE_LIM; then DMA wins.
  - Starve counter: increments on each contested cycle DMA loses; resets to 0 on any DMA grant or when dma_req=0.
  - CTRL.dma_en=0 → dma_gnt never asserts.
- cpu_stall = cpu_req & ~cpu_granted. dma_gnt = dma_req & dma_granted.
- Writes commit at the granting clock edge.
- Reads: data returned the cycle after grant. rvalid pulses 1 cycle on the owner's port only. rdata holds its last value when rvalid=0.
- Back-to-back grants supported: one access per cycle throughput; a read followed by a write to the same word returns the old data.
- Register window (word offsets):
  - 0 CYCLES: RO, +1 every cycle, wraps at 2^32.
  - 1 DMA_CNT: RO, +1 per DMA grant, wraps.
  - 2 CTRL: RW, bit0 dma_en; other bits read 0.
  - 3 STATUS: bit0 = err_addr; writing 1 to bit0 clears it.
  - Writes to RO registers are ignored.
- Out-of-range access: read returns 0 with normal rvalid timing; write dropped; err_addr sets next cycle.
  - Set and clear in the same cycle: set wins.
- Reset mid-read: pending rvalid cancelled.

Optional Feature:
- Macro BYTE_WE_EN.
- Defined: adds ports cpu_be and dma_be (in, DATA_W/8). A write updates only lanes whose be bit = 1. A register write with any be bit set writes the full register.
- Undefined: no be ports; all lanes written.

Decomposition:
- Package dmem_pkg:
  - owner_t enum {OWN_NONE, OWN_CPU, OWN_DMA}
  - region_t enum {REG_RAM, REG_IO, REG_OOR}
  - IO offset constants: IO_CYCLES=0, IO_DMACNT=1, IO_CTRL=2, IO_STATUS=3
  - CTRL_DMA_EN_BIT
- Sub-module dmem_ram: single-port synchronous RAM, parametrised depth and width, optional byte lanes. Arbitration and IO logic stay in dmem_subsystem.

Test Plan:
- CPU write 0xDEADBEEF @0x10, then CPU read 0x10 → cpu_stall=0 both cycles; cpu_rvalid=1 one cycle later with cpu_rdata=0xDEADBEEF; dma_rvalid=0.
- CTRL=1, STARVE_LIM=4, CPU and DMA request continuously → DMA granted on cycle 5, then every 5th cycle; cpu_stall=1 exactly on those cycles; DMA_CNT increments per grant.
- CTRL=0, dma_req held high for 10 cycles → dma_gnt stays 0; DMA_CNT stays 0.
- CPU write to 0x2000 (DEPTH_WORDS=1024) → RAM unchanged; err_addr=1; read of STATUS returns 1; write 1 to STATUS → err_addr=0.
- Read CYCLES twice 3 cycles apart → values differ by 3; write 0x55 to CYCLES → value not overwritten.
- Assert reset during an outstanding read → rvalid never asserts; all outputs 0; after release, CTRL reads 0.
